apb_cmd_master: RTL
===================

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, max consecutive ACCESS cycles with PREADY=0 before abort; 0 disables timeout.
REQ-002 Parameter ADDR_W, default 32, PADDR/cmd_addr width.
REQ-003 Parameter DATA_W, default 32, PWDATA/PRDATA/cmd_wdata/rsp_rdata width.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 PCLK  in  1  clock, all state on rising edge.
REQ-006 PRESET  in  1  synchronous active-high reset.
REQ-007 cmd_valid  in  1  command request.
REQ-008 cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready at rising edge.
REQ-009 cmd_write  in  1  1=write, 0=read.
REQ-010 cmd_addr  in  ADDR_W  target address.
REQ-011 cmd_wdata  in  DATA_W  write data.
REQ-012 rsp_valid  out  1  response available.
REQ-013 rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready at rising edge.
REQ-014 rsp_rdata  out  DATA_W  read data; 0 for writes and on timeout.
REQ-015 rsp_err  out  1  1=transfer aborted by timeout.
REQ-016 PSEL, PENABLE, PWRITE  out  1 each  APB control.
REQ-017 PADDR  out  ADDR_W; PWDATA  out  DATA_W  APB address/write data.
REQ-018 PRDATA  in  DATA_W; PREADY  in  1  APB slave response.

Function
REQ-019 FSM states IDLE, SETUP, ACCESS, RESP; exactly one transfer outstanding.
REQ-020 cmd_ready SHALL be 1 only in IDLE (combinational from state, independent of cmd_valid).
REQ-021 IDLE: on acceptance capture cmd_write/addr/wdata into registers, go SETUP; otherwise stay.
REQ-022 SETUP (one cycle): PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA from captured registers; next state ACCESS unconditionally.
REQ-023 ACCESS: PSEL=1, PENABLE=1, address/control/data held stable; PREADY=1 -> RESP, rsp_rdata<=PRDATA if read else 0, rsp_err<=0.
REQ-024 ACCESS with PREADY=0: wait counter increments; on the TIMEOUT_CYCLES-th consecutive PREADY=0 cycle -> RESP, rsp_err<=1, rsp_rdata<=0.
REQ-025 Wait counter cleared on entry to ACCESS; width $clog2(TIMEOUT_CYCLES+1), never wraps.
REQ-026 Accept-to-completion latency with zero wait states: accept edge k, SETUP cycle k+1, ACCESS k+2, rsp_valid=1 in cycle k+3.
REQ-027 RESP: rsp_valid=1, PSEL=PENABLE=0; rsp_rdata/rsp_err held until rsp_valid&&rsp_ready, then IDLE.
REQ-028 No back-to-back bypass: next command accepted at earliest the cycle after RESP exits.
REQ-029 Outside SETUP/ACCESS, PSEL=PENABLE=0; PADDR/PWDATA/PWRITE hold last captured value.
REQ-030 cmd_* inputs ignored outside IDLE; PRDATA/PREADY ignored outside ACCESS.

Reset
REQ-031 PRESET=1 at any edge, including mid-transfer: state IDLE, PSEL=PENABLE=PWRITE=0, PADDR=PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter 0; cmd_ready=1 in the first cycle after reset deasserts.
REQ-032 Reset dominates cmd_valid, PREADY and rsp_ready in the same cycle.

Structure
REQ-033 Package apb_pkg holds the state enum (IDLE, SETUP, ACCESS, RESP) and the default ADDR_W/DATA_W constants.
REQ-034 One sub-module apb_timeout_cnt (clear, enable, expired output, parameter TIMEOUT_CYCLES); everything else in apb_cmd_master.

Verification
REQ-035 Write 0x0000_0004 data 0xDEAD_BEEF, PREADY=1 -> PSEL rises cycle k+1, PENABLE k+2, rsp_valid k+3, rsp_err=0, rsp_rdata=0.
REQ-036 Read 0x10 with slave returning 0x1234_5678 and PREADY low 3 ACCESS cycles -> ACCESS lasts 4 cycles, PADDR stable, rsp_rdata=0x1234_5678, rsp_err=0.
REQ-037 TIMEOUT_CYCLES=16, PREADY held 0 -> exactly 16 ACCESS cycles, then PSEL=0, rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-038 rsp_ready held 0 for 5 cycles while cmd_valid=1 -> rsp_valid/rsp_rdata stable, cmd_ready=0, no SETUP until rsp_ready=1 handshake.
REQ-039 PRESET asserted during ACCESS of a write -> next cycle all outputs at reset values, cmd_ready=1, no rsp_valid for the aborted transfer.
REQ-040 cmd_valid toggling with changing cmd_addr during SETUP/ACCESS -> PADDR equals value captured at acceptance.

Source files
------------

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared state encoding and default widths for the APB command master
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

endpackage

// File: rtl/apb_timeout_cnt.sv
// rtl/apb_timeout_cnt.sv - saturating wait-state counter that flags the last permitted stall cycle
module apb_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic PCLK,
  input  logic PRESET,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST  = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge PCLK) begin
    if (PRESET || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Expiry is combinational so the Nth stalled cycle itself ends the transfer.
  assign o_expired = (TIMEOUT_CYCLES > 0) && i_enable && (r_cnt == LAST);

endmodule

// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - single-outstanding command/response to APB master bridge with wait timeout
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  apb_state_t        r_state;
  apb_state_t        w_next;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic              w_expired;
  logic              w_done;

  apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .i_clear  (r_state != ACCESS),
    .i_enable ((r_state == ACCESS) && !PREADY),
    .o_expired(w_expired)
  );

  assign w_done = (r_state == ACCESS) && (PREADY || w_expired);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_next = SETUP;
      end
      SETUP: begin
        PSEL   = 1'b1;
        w_next = ACCESS;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (w_done) w_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Captured command and response registers hold until the next capture/completion.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      if ((r_state == IDLE) && cmd_valid) begin
        r_pwrite <= cmd_write;
        r_paddr  <= cmd_addr;
        r_pwdata <= cmd_wdata;
      end
      if (w_done) begin
        r_err   <= !PREADY;
        r_rdata <= (PREADY && !r_pwrite) ? PRDATA : '0;
      end
    end
  end

  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule
